// File: rtl/kmap_sweep_checker_if.sv
// Bus between the sweep checker and the minimized two-function logic block.
// The checker (slave) drives the variable buses and reports results;
// the block / environment (master) supplies start and the f1/f2 responses.
interface kmap_sweep_checker_if;
    logic        start;
    logic        f1_in;
    logic        f2_in;
    logic [3:0]  abcd_out;
    logic [3:0]  wxyz_out;
    logic        busy;
    logic        done;
    logic [15:0] tt_f1;
    logic [15:0] tt_f2;
    logic [5:0]  err_count;
    logic        first_err_vld;
    logic [4:0]  first_err_idx;
    logic        pass;

    modport slave (
        input  start, f1_in, f2_in,
        output abcd_out, wxyz_out, busy, done, tt_f1, tt_f2,
               err_count, first_err_vld, first_err_idx, pass
    );

    modport master (
        output start, f1_in, f2_in,
        input  abcd_out, wxyz_out, busy, done, tt_f1, tt_f2,
               err_count, first_err_vld, first_err_idx, pass
    );
endinterface

// File: rtl/kmap_sweep_checker.sv
// Self-check stage for the minimized f1/f2 logic block. Walks all 16 minterms
// on both variable buses, samples f1/f2 after a settle time, compares against
// the unminimized golden SOPs and reports truth tables, error count, first
// failing minterm and a pass flag. Every output comes straight from a register.
module kmap_sweep_checker #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    kmap_sweep_checker_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  idx_q;
    logic [3:0]  wait_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [15:0] tt_f1_q;
    logic [15:0] tt_f2_q;
    logic [5:0]  err_q;
    logic        fev_q;
    logic [4:0]  fei_q;

    logic        gold1;
    logic        gold2;
    logic        mis1;
    logic        mis2;
    logic [5:0]  err_d;

    // Golden f1 = a'b'c'd' + ac'd' + b'cd' + a'bcd + bc'd, index = {a,b,c,d}
    function automatic logic gold_f1(input logic [3:0] m);
        logic a, b, c, d;
        {a, b, c, d} = m;
        return (!a && !b && !c && !d) || (a && !c && !d) || (!b && c && !d) ||
               (!a && b && c && d) || (b && !c && d);
    endfunction

    // Golden f2 = xy'z + x'y'z + w'xy + wx'y + wxy, index = {w,x,y,z}
    function automatic logic gold_f2(input logic [3:0] m);
        logic w, x, y, z;
        {w, x, y, z} = m;
        return (x && !y && z) || (!x && !y && z) || (!w && x && y) ||
               (w && !x && y) || (w && x && y);
    endfunction

    // Compare the sampled outputs with the golden values for the current minterm
    always_comb begin
        gold1 = gold_f1(idx_q);
        gold2 = gold_f2(idx_q);
        mis1  = bus.f1_in ^ gold1;
        mis2  = bus.f2_in ^ gold2;
        err_d = err_q + {5'd0, mis1} + {5'd0, mis2};
    end

    // Sweep FSM with all result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tt_f1_q <= '0;
            tt_f2_q <= '0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fei_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q <= DRIVE;
                        idx_q   <= '0;
                        wait_q  <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        tt_f1_q <= '0;
                        tt_f2_q <= '0;
                        err_q   <= '0;
                        fev_q   <= 1'b0;
                        fei_q   <= '0;
                    end
                end
                DRIVE: begin
                    if (wait_q == SETTLE_LAST) begin
                        wait_q  <= '0;
                        state_q <= SAMPLE;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                SAMPLE: begin
                    tt_f1_q[idx_q] <= bus.f1_in;
                    tt_f2_q[idx_q] <= bus.f2_in;
                    err_q          <= err_d;
                    // Only the first failing minterm is kept; f1 wins a tie
                    if (!fev_q && (mis1 || mis2)) begin
                        fev_q <= 1'b1;
                        fei_q <= {!mis1, idx_q};
                    end
                    if (idx_q == 4'd15) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == 6'd0);
                    end else begin
                        idx_q   <= idx_q + 4'd1;
                        state_q <= DRIVE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Index register drives both variable buses; DONE leaves it at 15
    assign bus.abcd_out      = idx_q;
    assign bus.wxyz_out      = idx_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.tt_f1         = tt_f1_q;
    assign bus.tt_f2         = tt_f2_q;
    assign bus.err_count     = err_q;
    assign bus.first_err_vld = fev_q;
    assign bus.first_err_idx = fei_q;

endmodule
